// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: debounced single-step / free-run CPU clock generator
//   clk      board clock, all logic on its rising edge
//   rst      asynchronous active-low reset
//   btn_step raw step pushbutton (async, bouncy)
//   sw_run   raw mode switch, 1 = free-run, 0 = single-step
//   cpu_clk  generated CPU clock, straight from a flop
//   busy     high whenever the FSM is not idle
//   step_cnt count of cpu_clk rising edges since reset
module cpu_clk_ctrl #(
  parameter int DEB_CYCLES   = 1_000_000,
  parameter int PULSE_CYCLES = 1024,
  parameter int RUN_HALF     = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_step,
  input  logic        sw_run,
  output logic        cpu_clk,
  output logic        busy,
  output logic [31:0] step_cnt
);
  typedef enum logic [2:0] {S_STEP_IDLE, S_STEP_HI, S_STEP_LO, S_RUN_LO, S_RUN_HI} state_t;
  state_t state, nxt;
  logic [1:0] s1, s2, deb;
  logic btn_d, step_req, pulse_done, half_done, nxt_hi;
  logic [31:0] pc;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {s2, s1} <= '0;
    else {s2, s1} <= {s1, sw_run, btn_step};
  for (genvar i = 0; i < 2; i++) begin : g_deb
    logic [31:0] cnt;
    logic d;
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        cnt <= '0;
        d <= 1'b0;
      end else if (s2[i] == d) cnt <= '0;
      else if (cnt == 32'(DEB_CYCLES - 1)) begin
        cnt <= '0;
        d <= s2[i];
      end else cnt <= cnt + 32'd1;
    assign deb[i] = d;
  end
  assign step_req = deb[0] & ~btn_d;
  assign pulse_done = pc == 32'(PULSE_CYCLES - 1);
  assign half_done = pc == 32'(RUN_HALF - 1);
  // run wins over a same-cycle step request; requests outside idle are dropped
  always_comb begin
    nxt = state;
    case (state)
      S_STEP_IDLE: nxt = deb[1] ? S_RUN_LO : step_req ? S_STEP_HI : S_STEP_IDLE;
      S_STEP_HI:   nxt = pulse_done ? S_STEP_LO : S_STEP_HI;
      S_STEP_LO:   nxt = pulse_done ? S_STEP_IDLE : S_STEP_LO;
      S_RUN_LO:    nxt = !half_done ? S_RUN_LO : deb[1] ? S_RUN_HI : S_STEP_IDLE;
      S_RUN_HI:    nxt = half_done ? S_RUN_LO : S_RUN_HI;
      default:     nxt = S_STEP_IDLE;
    endcase
  end
  assign nxt_hi = nxt == S_STEP_HI || nxt == S_RUN_HI;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_STEP_IDLE;
      pc <= '0;
      cpu_clk <= 1'b0;
      busy <= 1'b0;
      step_cnt <= '0;
      btn_d <= 1'b0;
    end else begin
      state <= nxt;
      pc <= nxt != state ? '0 : pc + 32'd1;
      cpu_clk <= nxt_hi;
      busy <= nxt != S_STEP_IDLE;
      btn_d <= deb[0];
      if (nxt_hi && nxt != state) step_cnt <= step_cnt + 32'd1;
    end
endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl: directed self-checking bench for cpu_clk_ctrl
module tb_cpu_clk_ctrl;
  logic clk = 1'b0, rst = 1'b0, btn_step = 1'b0, sw_run = 1'b0;
  logic cpu_clk, busy;
  logic [31:0] step_cnt;
  logic [63:0] hc, hb;
  logic [29:0] bp;
  logic acc;
  int tests = 0, fails = 0;
  cpu_clk_ctrl #(.DEB_CYCLES(4), .PULSE_CYCLES(2), .RUN_HALF(3)) dut (
    .clk(clk), .rst(rst), .btn_step(btn_step), .sw_run(sw_run),
    .cpu_clk(cpu_clk), .busy(busy), .step_cnt(step_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input int n, output logic [63:0] c, output logic [63:0] b);
    c = '0;
    b = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      c[k] = cpu_clk;
      b[k] = busy;
    end
  endtask
  task automatic do_reset();
    btn_step = 1'b0;
    sw_run = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask
  initial begin
    btn_step = 1'($urandom_range(1));
    sw_run = 1'($urandom_range(1));
    repeat (3) @(negedge clk);
    chk("rst_cpu_clk", cpu_clk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_step_cnt", step_cnt, 0);
    btn_step = 1'b0;
    sw_run = 1'b0;
    rst = 1'b1;
    run(50, hc, hb);
    chk("idle_quiet", hc | hb | 64'(step_cnt), 0);
    do_reset();
    btn_step = 1'b1;
    run(20, hc, hb);
    chk("press_cpu_clk", hc, 64'hC0);
    chk("press_busy", hb, 64'h3C0);
    chk("press_cnt", step_cnt, 1);
    btn_step = 1'b0;
    run(20, hc, hb);
    chk("release_quiet", hc | hb, 0);
    chk("release_cnt", step_cnt, 1);
    do_reset();
    btn_step = 1'b1;
    run(3, hc, hb);
    btn_step = 1'b0;
    run(25, hc, hb);
    chk("glitch_quiet", hc | hb, 0);
    chk("glitch_cnt", step_cnt, 0);
    bp = 30'b110100110001110110100011101000;
    acc = 1'b0;
    for (int k = 29; k >= 0; k--) begin
      btn_step = bp[k];
      @(negedge clk);
      acc = acc | cpu_clk | busy;
    end
    chk("bounce_quiet", acc, 0);
    btn_step = 1'b1;
    run(20, hc, hb);
    chk("bounce_settle", hc, 64'hC0);
    chk("bounce_cnt", step_cnt, 1);
    do_reset();
    btn_step = 1'b1;
    run(7, hc, hb);
    chk("pulse1_rise", hc, 64'h40);
    btn_step = 1'b0;
    run(2, hc, hb);
    btn_step = 1'b1;
    run(13, hc, hb);
    chk("repress_ignored", hc, 0);
    btn_step = 1'b0;
    run(20, hc, hb);
    chk("repress_cnt", step_cnt, 1);
    btn_step = 1'b1;
    run(20, hc, hb);
    chk("second_press", hc, 64'hC0);
    chk("second_cnt", step_cnt, 2);
    do_reset();
    sw_run = 1'b1;
    run(24, hc, hb);
    chk("run_wave", hc, 64'hE38E00);
    run(36, hc, hb);
    chk("run_cnt9", step_cnt, 9);
    sw_run = 1'b0;
    run(20, hc, hb);
    chk("run_stop_wave", hc, 64'h38);
    chk("run_stop_busy", hb, 64'h1FF);
    chk("run_cnt10", step_cnt, 10);
    do_reset();
    sw_run = 1'b1;
    run(11, hc, hb);
    chk("midrun_high", cpu_clk, 1);
    chk("midrun_cnt", step_cnt, 1);
    rst = 1'b0;
    #1;
    chk("async_cpu_clk", cpu_clk, 0);
    chk("async_cnt", step_cnt, 0);
    chk("async_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    run(24, hc, hb);
    chk("resume_wave", hc, 64'hE38E00);
    chk("resume_cnt", step_cnt, 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
